// File: rtl/mem_copy_engine.sv
// Block-copy bus initiator for the single-port data memory: one read then one write per byte.
// Optional running byte checksum on reads when MEM_COPY_CHECKSUM_EN is defined.
module mem_copy_engine #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] SrcAddr,
  input  logic [ADDR_W-1:0] DstAddr,
  input  logic [ADDR_W-1:0] Len,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] DataAddress,
  output logic              ReadMem,
  output logic              WriteMem,
  output logic [DATA_W-1:0] DataIn,
  input  logic [DATA_W-1:0] DataOut
`ifdef MEM_COPY_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] Checksum
`endif
);

  localparam logic [ADDR_W-1:0] One = 1;

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [ADDR_W-1:0] i_q, i_d;
  logic [DATA_W-1:0] data_q, data_d;
`ifdef MEM_COPY_CHECKSUM_EN
  logic [DATA_W-1:0] cs_q, cs_d;
  assign Checksum = cs_q;
`endif

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q <= StIdle;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      i_q     <= '0;
      data_q  <= '0;
`ifdef MEM_COPY_CHECKSUM_EN
      cs_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      i_q     <= i_d;
      data_q  <= data_d;
`ifdef MEM_COPY_CHECKSUM_EN
      cs_q    <= cs_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    dst_d       = dst_q;
    len_d       = len_q;
    i_d         = i_q;
    data_d      = data_q;
`ifdef MEM_COPY_CHECKSUM_EN
    cs_d        = cs_q;
`endif
    busy        = 1'b0;
    done        = 1'b0;
    ReadMem     = 1'b0;
    WriteMem    = 1'b0;
    DataAddress = '0;
    DataIn      = '0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          src_d   = SrcAddr;
          dst_d   = DstAddr;
          len_d   = Len;
          i_d     = '0;
`ifdef MEM_COPY_CHECKSUM_EN
          cs_d    = '0;
`endif
          state_d = (Len == '0) ? StDone : StRead;
        end
      end
      StRead: begin
        busy        = 1'b1;
        ReadMem     = 1'b1;
        DataAddress = src_q + i_q;
        data_d      = DataOut;
`ifdef MEM_COPY_CHECKSUM_EN
        cs_d        = cs_q + DataOut;
`endif
        state_d     = StWrite;
      end
      StWrite: begin
        busy        = 1'b1;
        WriteMem    = 1'b1;
        DataAddress = dst_q + i_q;
        DataIn      = data_q;
        if (i_q == len_q - One) begin
          state_d = StDone;
        end else begin
          i_d     = i_q + One;
          state_d = StRead;
        end
      end
      StDone: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Outputs sit at their reset values while reset is held, so an in-flight write never commits.
    if (reset) begin
      busy        = 1'b0;
      done        = 1'b0;
      ReadMem     = 1'b0;
      WriteMem    = 1'b0;
      DataAddress = '0;
      DataIn      = '0;
    end
  end

endmodule

// File: doc/mem_copy_engine.md
Name: mem_copy_engine

Overview:
- Bus initiator that drives the single-port data memory (8-bit address, 8-bit data, combinational read, synchronous write) to copy a block of bytes from a source region to a destination region.
- Sits beside the processor core on the data-memory port. The core hands over the port while busy is high.
- Uses one address pointer per memory cycle, so each byte costs one read cycle followed by one write cycle.

Parameters:
ADDR_W, 8, memory address width; also the width of Len and the internal counter
DATA_W, 8, memory data width

Ports:
CLK  input  1  clock
reset  input  1  synchronous, active-high; clock CLK
start  input  1  one-cycle request to begin a copy; sampled only in IDLE
SrcAddr  input  ADDR_W  first source byte address; latched on accepted start
DstAddr  input  ADDR_W  first destination byte address; latched on accepted start
Len  input  ADDR_W  byte count, 0..255; latched on accepted start
busy  output  1  high from the cycle after start is accepted until done is asserted, inclusive
done  output  1  one-cycle completion pulse
DataAddress  output  ADDR_W  memory address
ReadMem  output  1  memory read enable
WriteMem  output  1  memory write enable
DataIn  output  DATA_W  write data to memory
DataOut  input  DATA_W  read data from memory; valid combinationally while ReadMem=1

Behaviour:
- Reset values: busy=0, done=0, ReadMem=0, WriteMem=0, DataAddress=0, DataIn=0. The FSM goes to IDLE and the internal counter and buffer clear to 0.
- States are IDLE, READ, WRITE, DONE.
- IDLE:
  - All memory outputs are 0.
  - When start=1 at a posedge, latch SrcAddr, DstAddr and Len, and clear counter i.
  - If Len=0, go to DONE; otherwise go to READ.
- READ:
  - ReadMem=1, WriteMem=0, DataAddress=src+i (mod 256).
  - At the posedge, capture DataOut into the byte buffer and go to WRITE.
- WRITE:
  - WriteMem=1, ReadMem=0, DataAddress=dst+i (mod 256), DataIn=buffer.
  - At the posedge, if i==Len-1 go to DONE; otherwise i<=i+1 and go to READ.
- DONE:
  - done=1 and busy=1 for exactly one cycle, memory outputs are 0, then go to IDLE.
- Latency: if start is accepted at edge t, done is high during cycle 2*Len+1 after t. Len=0 gives done in the first cycle.
- busy is high in the READ, WRITE and DONE states.
- ReadMem and WriteMem are never high together. DataAddress, DataIn, ReadMem and WriteMem are driven from registered state with no combinational path from start.
- start while not in IDLE is ignored, and the latched parameters do not change mid-copy.
- Address wrap: src+i and dst+i wrap modulo 2^ADDR_W. For example, src=0xFE with Len=4 reads 0xFE, 0xFF, 0x00, 0x01.
- Overlap: the copy always runs in ascending order. With dst>src and overlapping regions, the source pattern replicates. This is defined behaviour, not an error.
- src==dst: full read/write sequence still runs; memory content is unchanged.
- Reset mid-copy: the engine returns to IDLE the next cycle with all outputs at their reset values and no done pulse. Bytes already written stay written, unless the memory is also reset.
- start and reset high in the same cycle: reset wins and start is dropped.

Optional Feature:
- Macro: MEM_COPY_CHECKSUM_EN.
- When defined:
  - Adds output Checksum (DATA_W). It is cleared to 0 on reset and on each accepted start.
  - In each READ cycle it updates to Checksum+DataOut (mod 2^DATA_W).
  - It holds its value after done until the next accepted start.
- When undefined: the port and its logic are absent, and all other behaviour is identical.

Test Plan:
- Basic copy: preload M[0x10..0x13]=0x11,0x22,0x33,0x44; start with Src=0x10, Dst=0x80, Len=4.
  - Required: M[0x80..0x83]=0x11,0x22,0x33,0x44.
  - done pulses exactly 9 cycles after start is accepted; busy is high for 9 cycles.
  - With MEM_COPY_CHECKSUM_EN, Checksum=0xAA.
- Zero length: start with Len=0.
  - Required: done in cycle 1, no ReadMem or WriteMem assertion, memory unchanged.
- Wrap-around: Src=0xFE, Dst=0x40, Len=3, with M[0xFE]=1, M[0xFF]=2, M[0x00]=3.
  - Required: M[0x40..0x42]=1,2,3; read addresses seen are 0xFE, 0xFF, 0x00.
- Overlapping forward copy: M[0x20]=0xA5, Src=0x20, Dst=0x21, Len=3.
  - Required: M[0x21..0x23]=0xA5.
- Busy and reset handling:
  - Re-issue start with different parameters while busy: it is ignored, and only the original region is written.
  - Assert reset during the third WRITE of a Len=5 copy: outputs drop to 0 the next cycle, no done pulse, exactly 2 destination bytes are updated.
- Protocol monitor across all tests:
  - ReadMem and WriteMem are never both 1.
  - Every WRITE immediately follows a READ at the same index.
